// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_HOLD     = 2'd0,
    PC_INC      = 2'd1,
    PC_REDIRECT = 2'd2
  } pc_sel_e;

  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  // Sequential successor; wraps modulo 2^32.
  function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
    return pc + 32'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// Program counter register with hold / sequential / redirect next-pc selection.
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  pc_sel_e     sel_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    case (sel_i)
      PC_INC:      pc_d = next_seq_pc(pc_q);
      PC_REDIRECT: pc_d = redirect_pc_i;
      default:     pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, issues one imem request at a time, fills the IF slot.
// Optional perf counters (perf_fetched, perf_stall_cyc) exist only with FETCH_PERF_EN defined.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef FETCH_PERF_EN
  ,
  parameter int unsigned PERF_W   = 32
`endif
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  output logic         imem_req_valid,
  output logic [31:0]  imem_req_addr,
  input  logic         imem_req_ready,
  input  logic         imem_rsp_valid,
  input  logic [31:0]  imem_rsp_data,
  output logic         if_valid,
  output logic [31:0]  if_pc,
  output logic [31:0]  if_instr,
  output fetch_state_e dbg_state
`ifdef FETCH_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_fetched,
  output logic [PERF_W-1:0] perf_stall_cyc
`endif
);

  // Handshake: a request transfers on a cycle where imem_req_valid && imem_req_ready;
  // valid may be withdrawn or retargeted before that. Each transfer yields exactly one
  // imem_rsp_valid pulse later; the slot is consumed on a cycle where if_valid && !stall.

  fetch_state_e state_q, state_d;
  logic         if_valid_q, if_valid_d;
  logic [31:0]  if_pc_q, if_pc_d;
  logic [31:0]  if_instr_q, if_instr_d;
  logic [31:0]  pc;
  pc_sel_e      pc_sel;
  logic         fill;
  logic         slot_free;

  fetch_pc_gen #(
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk           (clk),
    .rst_n         (rst_n),
    .sel_i         (pc_sel),
    .redirect_pc_i (redirect_pc),
    .pc_o          (pc)
  );

  assign slot_free = !if_valid_q || !stall;

  always_comb begin
    state_d        = state_q;
    pc_sel         = PC_HOLD;
    fill           = 1'b0;
    imem_req_valid = 1'b0;
    if_valid_d     = if_valid_q && stall;
    if_pc_d        = if_pc_q;
    if_instr_d     = if_instr_q;

    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        imem_req_valid = slot_free;
        if (redirect_valid) begin
          pc_sel = PC_REDIRECT;
          // An accepted request is already at imem; its response must be drained.
          if (slot_free && imem_req_ready) state_d = DRAIN;
        end else if (slot_free && imem_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_sel  = PC_REDIRECT;
          state_d = imem_rsp_valid ? REQ : DRAIN;
        end else if (imem_rsp_valid) begin
          fill    = 1'b1;
          pc_sel  = PC_INC;
          state_d = REQ;
        end
      end
      DRAIN: begin
        if (redirect_valid) pc_sel = PC_REDIRECT;
        if (imem_rsp_valid) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase

    if (fill) begin
      if_valid_d = 1'b1;
      if_pc_d    = pc;
      if_instr_d = imem_rsp_data;
    end
    if (redirect_valid && state_q != IDLE) if_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      if_valid_q <= 1'b0;
      if_pc_q    <= 32'h0;
      if_instr_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
    end
  end

  assign imem_req_addr = pc;
  assign if_valid      = if_valid_q;
  assign if_pc         = if_pc_q;
  assign if_instr      = if_instr_q;
  assign dbg_state     = state_q;

`ifdef FETCH_PERF_EN
  logic [PERF_W-1:0] fetched_q;
  logic [PERF_W-1:0] stall_cyc_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetched_q   <= '0;
      stall_cyc_q <= '0;
    end else begin
      if (fill)                fetched_q   <= fetched_q + PERF_W'(1);
      if (if_valid_q && stall) stall_cyc_q <= stall_cyc_q + PERF_W'(1);
    end
  end

  assign perf_fetched   = fetched_q;
  assign perf_stall_cyc = stall_cyc_q;
`endif

endmodule
